mem_stage_periph: RTL and testbench
===================================

Name: mem_stage_periph

Overview:
- MEM-stage data-side block of the pipelined CPU. Sits between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Decodes the ALU-computed address to one of two targets: word-addressed data RAM, or memory-mapped peripherals (timer, LEDs, switches, 7-seg, systick).
- Returns read data combinationally, so the MEM/WB register captures it in the same cycle.
- Raises the timer interrupt request to the control path.

Parameters:
- RAM_WORDS, 256, number of 32-bit data RAM words.
- RAM_AW, 8, RAM word-address width; log2(RAM_WORDS).
- PERIPH_BASE, 32'h4000_0000, base address of the peripheral window.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- mem_read  input  1  load in MEM stage this cycle.
- mem_write  input  1  store in MEM stage this cycle.
- addr  input  32  byte address from EX/MEM.
- wdata  input  32  store data.
- rdata  output  32  load data, combinational.
- switch  input  8  board switches.
- led  output  8  LED register.
- digi  output  12  7-seg register: [11:8] anode select, [7:0] segments.
- irq  output  1  timer interrupt request.

Behaviour:
- Clocking and reset:
  - One clock; reset is asynchronous and active-low.
  - While reset=0: TH=0, TL=0, TCON=0, led=0, digi=0, systick=0, so irq=0.
  - RAM contents are not reset.
- Address map (all word accesses; addr[1:0] ignored):
  - RAM: addr < RAM_WORDS*4. Word index = addr[RAM_AW+1:2].
  - PERIPH_BASE+0x00: TH, read/write.
  - +0x04: TL, read/write.
  - +0x08: TCON[2:0], read/write. Bit0 = enable, bit1 = irq enable, bit2 = irq status. Bits 31:3 read 0.
  - +0x0C: led[7:0], read/write.
  - +0x10: switch, read-only; writes ignored; reads zero-extended.
  - +0x14: digi[11:0], read/write.
  - +0x18: systick, read-only.
  - Any other address: reads return 0, writes are ignored.
- Reads:
  - rdata = selected word when mem_read=1, else 0.
  - rdata is purely combinational from addr and current register/RAM state. Zero latency.
- Writes:
  - Take effect at the rising clk edge when mem_write=1. Visible to reads from the next cycle.
  - If mem_read and mem_write are both 1 in the same cycle, rdata shows the old value and the write lands at the edge.
- Timer (each edge):
  - If TCON[0]=1 and TL=32'hFFFF_FFFF: TL<=TH, and TCON[2]<=1 if TCON[1]=1.
  - Else if TCON[0]=1: TL<=TL+1, wrapping modulo 2^32.
  - If TCON[0]=0, TL holds.
  - TCON[2] is sticky. Software clears it by writing TCON.
- irq = TCON[1] & TCON[2], combinational from registers.
- systick increments every cycle, wrapping at 2^32. It is not writable.
- Simultaneous events:
  - Software write to TL or TCON in the same cycle as a timer update or overflow: the software write wins for the whole register.
  - A TH write in the overflow cycle: TL reloads the old TH.
- Reset mid-operation: asserting reset during a store aborts it. Peripheral registers clear immediately. A RAM write in flight on the same edge is not performed.

Decomposition:
- Shared package holds:
  - Peripheral offset constants: TH, TL, TCON, LED, SW, DIGI, SYSTICK.
  - TCON bit indices: EN=0, IE=1, IS=2.
  - PERIPH_BASE.
- One natural sub-module, periph_timer: holds TH/TL/TCON, reload/overflow logic and irq.
- RAM array, address decode and read mux stay in the top level.

Test Plan:
- Reset: hold reset=0 mid-count, then release -> led=0, digi=0, irq=0. Read of TCON returns 0. systick read in the first post-reset cycle = 0.
- RAM: store 32'hDEAD_BEEF to 0x0000_0010, then load 0x0000_0010 next cycle -> rdata=32'hDEAD_BEEF. Load 0x0000_0400 (out of range) -> rdata=0.
- Timer reload and irq:
  - Setup: TH=32'hFFFF_FFFC, TL=32'hFFFF_FFFE, TCON=3'b011.
  - Expected: TL goes FFFF_FFFF after 1 edge, then FFFF_FFFC. irq=1 from the cycle after the overflow edge.
  - Write TCON=3'b011 -> irq drops next cycle.
- Collision: write TL=5 on the exact overflow edge -> TL=5 and TCON[2] unchanged. Next edge -> TL=6.
- Peripherals:
  - switch=8'hA5, load PERIPH_BASE+0x10 -> rdata=32'h0000_00A5.
  - Store 8'h3C to +0x0C -> led=8'h3C next cycle.
  - Store to +0x10 -> no effect.
- Read/write same cycle: RAM word holds 7; assert mem_read=mem_write=1 with wdata=9 -> rdata=7 that cycle, 9 the next.

Source files
------------

// File: rtl/mem_stage_periph_pkg.sv
// Address map constants and decode helper shared by the MEM-stage data block.
// Constants only; no latency and no flow control.
package mem_stage_periph_pkg;

    localparam logic [31:0] PERIPH_BASE = 32'h4000_0000;

    localparam logic [31:0] OFF_TH      = 32'h00;
    localparam logic [31:0] OFF_TL      = 32'h04;
    localparam logic [31:0] OFF_TCON    = 32'h08;
    localparam logic [31:0] OFF_LED     = 32'h0C;
    localparam logic [31:0] OFF_SW      = 32'h10;
    localparam logic [31:0] OFF_DIGI    = 32'h14;
    localparam logic [31:0] OFF_SYSTICK = 32'h18;

    localparam int TCON_EN = 0;
    localparam int TCON_IE = 1;
    localparam int TCON_IS = 2;

    // Word-granular match: the byte-lane bits of the address are ignored.
    function automatic logic periph_hit(input logic [31:0] a,
                                        input logic [31:0] base,
                                        input logic [31:0] off);
        return {a[31:2], 2'b00} == (base + off);
    endfunction

endpackage

// File: rtl/mem_stage_periph_timer.sv
// Reloadable timer (TH/TL/TCON) with a sticky overflow flag and interrupt request.
// Software writes land at the next edge; irq is combinational from state; no backpressure.
module periph_timer
    import mem_stage_periph_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_th,
    input  logic        wr_tl,
    input  logic        wr_tcon,
    input  logic [31:0] wdata,
    output logic [31:0] th,
    output logic [31:0] tl,
    output logic [2:0]  tcon,
    output logic        irq
);

    logic ovf;

    assign ovf = tcon[TCON_EN] && (tl == 32'hFFFF_FFFF);
    assign irq = tcon[TCON_IE] & tcon[TCON_IS];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            th <= '0;
        end else if (wr_th) begin
            th <= wdata;
        end
    end

    // On overflow TL reloads the pre-edge TH, even if TH is written on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tl <= '0;
        end else if (wr_tl) begin
            tl <= wdata;
        end else if (ovf) begin
            tl <= th;
        end else if (tcon[TCON_EN]) begin
            tl <= tl + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tcon <= '0;
        end else if (wr_tcon) begin
            tcon <= wdata[2:0];
        end else if (ovf && tcon[TCON_IE]) begin
            tcon[TCON_IS] <= 1'b1;
        end
    end

endmodule

// File: rtl/mem_stage_periph.sv
// MEM-stage data side: word RAM plus memory-mapped timer, LEDs, switches, 7-seg and systick.
// Reads are combinational (zero latency); stores commit at the edge; never stalls the pipeline.
module mem_stage_periph #(
    parameter int          RAM_WORDS   = 256,
    parameter int          RAM_AW      = 8,
    parameter logic [31:0] PERIPH_BASE = mem_stage_periph_pkg::PERIPH_BASE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic [7:0]  switch,
    output logic [7:0]  led,
    output logic [11:0] digi,
    output logic        irq
);

    import mem_stage_periph_pkg::*;

    localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

    logic [31:0]       ram [RAM_WORDS];
    logic [RAM_AW-1:0] ram_idx;
    logic              ram_sel;
    logic              sel_th, sel_tl, sel_tcon, sel_led, sel_sw, sel_digi, sel_systick;
    logic [31:0]       th, tl, systick;
    logic [2:0]        tcon;

    assign ram_sel     = addr < RAM_BYTES;
    assign ram_idx     = addr[RAM_AW+1:2];
    assign sel_th      = periph_hit(addr, PERIPH_BASE, OFF_TH);
    assign sel_tl      = periph_hit(addr, PERIPH_BASE, OFF_TL);
    assign sel_tcon    = periph_hit(addr, PERIPH_BASE, OFF_TCON);
    assign sel_led     = periph_hit(addr, PERIPH_BASE, OFF_LED);
    assign sel_sw      = periph_hit(addr, PERIPH_BASE, OFF_SW);
    assign sel_digi    = periph_hit(addr, PERIPH_BASE, OFF_DIGI);
    assign sel_systick = periph_hit(addr, PERIPH_BASE, OFF_SYSTICK);

    periph_timer u_timer (
        .clk     (clk),
        .reset   (reset),
        .wr_th   (mem_write & sel_th),
        .wr_tl   (mem_write & sel_tl),
        .wr_tcon (mem_write & sel_tcon),
        .wdata   (wdata),
        .th      (th),
        .tl      (tl),
        .tcon    (tcon),
        .irq     (irq)
    );

    // RAM is not cleared, but a store coinciding with an asserted reset is dropped.
    always_ff @(posedge clk) begin
        if (reset && mem_write && ram_sel) begin
            ram[ram_idx] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            led  <= '0;
            digi <= '0;
        end else if (mem_write) begin
            if (sel_led)  led  <= wdata[7:0];
            if (sel_digi) digi <= wdata[11:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            systick <= '0;
        end else begin
            systick <= systick + 32'd1;
        end
    end

    always_comb begin
        rdata = '0;
        if (mem_read) begin
            if (ram_sel)          rdata = ram[ram_idx];
            else if (sel_th)      rdata = th;
            else if (sel_tl)      rdata = tl;
            else if (sel_tcon)    rdata = {29'd0, tcon};
            else if (sel_led)     rdata = {24'd0, led};
            else if (sel_sw)      rdata = {24'd0, switch};
            else if (sel_digi)    rdata = {20'd0, digi};
            else if (sel_systick) rdata = systick;
        end
    end

endmodule

// File: tb/tb_mem_stage_periph.sv
// Directed scenarios for mem_stage_periph; load results are checked through an expectation queue.
module tb_mem_stage_periph;

    localparam logic [31:0] PB        = 32'h4000_0000;
    localparam logic [31:0] A_TH      = PB + 32'h00;
    localparam logic [31:0] A_TL      = PB + 32'h04;
    localparam logic [31:0] A_TCON    = PB + 32'h08;
    localparam logic [31:0] A_LED     = PB + 32'h0C;
    localparam logic [31:0] A_SW      = PB + 32'h10;
    localparam logic [31:0] A_DIGI    = PB + 32'h14;
    localparam logic [31:0] A_SYSTICK = PB + 32'h18;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic [7:0]  switch = '0;
    logic [7:0]  led;
    logic [11:0] digi;
    logic        irq;

    int          tests_run = 0;
    int          tests_failed = 0;
    logic [31:0] exp_q[$];
    string       name_q[$];
    event        rd_ev;
    logic [31:0] tb_tick;

    mem_stage_periph dut (
        .clk       (clk),
        .reset     (reset),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .switch    (switch),
        .led       (led),
        .digi      (digi),
        .irq       (irq)
    );

    always #10 clk = ~clk;

    // Reference free-running counter: cleared by reset, +1 on every edge otherwise.
    always @(posedge clk or negedge reset) begin
        if (!reset) tb_tick <= '0;
        else        tb_tick <= tb_tick + 32'd1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    // Store: drive for one edge, return at the following negedge.
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr = a;
        wdata = d;
        mem_write = 1'b1;
        @(negedge clk);
        mem_write = 1'b0;
    endtask

    // Load: queue the expected value, then signal the scoreboard to sample rdata.
    task automatic rd(input logic [31:0] a, input logic [31:0] e, input string n);
        exp_q.push_back(e);
        name_q.push_back(n);
        addr = a;
        mem_read = 1'b1;
        #1;
        -> rd_ev;
        #1;
        mem_read = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        wr(A_LED, 32'h55);
        wr(A_DIGI, 32'h123);
        wr(A_TH, 32'h0);
        wr(A_TL, 32'hFFFF_FFFE);
        wr(A_TCON, 32'h3);
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if (irq !== 1'b1) begin
            tests_failed++;
            $display("FAIL pre_reset_irq: irq=%b expected 1", irq);
        end
        #3 reset = 1'b0;
        #1;
        tests_run++;
        if (led !== 8'h00 || digi !== 12'h000 || irq !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: led=%h digi=%h irq=%b expected 00 000 0", led, digi, irq);
        end
        @(negedge clk);
        reset = 1'b1;
        rd(A_SYSTICK, 32'h0, "systick_after_reset");
        rd(A_TCON, 32'h0, "tcon_after_reset");
        rd(A_TL, 32'h0, "tl_after_reset");
    endtask

    task automatic test_ram;
        @(negedge clk);
        wr(32'h0000_0010, 32'hDEAD_BEEF);
        rd(32'h0000_0010, 32'hDEAD_BEEF, "ram_load");
        rd(32'h0000_0013, 32'hDEAD_BEEF, "ram_byte_offset_ignored");
        rd(32'h0000_0400, 32'h0, "ram_out_of_range");
        @(negedge clk);
        addr = 32'h0000_0010;
        mem_read = 1'b0;
        #1;
        tests_run++;
        if (rdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL rdata_idle: rdata=%h expected 00000000", rdata);
        end
        @(negedge clk);
        wr(32'h0000_03FC, 32'h1234_5678);
        rd(32'h0000_03FC, 32'h1234_5678, "ram_last_word");
        rd(32'h0000_0010, 32'hDEAD_BEEF, "ram_no_alias");
    endtask

    task automatic test_timer;
        @(negedge clk);
        wr(A_TCON, 32'h0);
        wr(A_TH, 32'hFFFF_FFFC);
        wr(A_TL, 32'hFFFF_FFFE);
        wr(A_TCON, 32'h3);
        rd(A_TL, 32'hFFFF_FFFE, "tl_enable_edge");
        @(negedge clk);
        rd(A_TL, 32'hFFFF_FFFF, "tl_count");
        tests_run++;
        if (irq !== 1'b0) begin
            tests_failed++;
            $display("FAIL irq_before_ovf: irq=%b expected 0", irq);
        end
        @(negedge clk);
        rd(A_TL, 32'hFFFF_FFFC, "tl_reload");
        rd(A_TCON, 32'h7, "tcon_status_set");
        tests_run++;
        if (irq !== 1'b1) begin
            tests_failed++;
            $display("FAIL irq_after_ovf: irq=%b expected 1", irq);
        end
        wr(A_TCON, 32'h3);
        tests_run++;
        if (irq !== 1'b0) begin
            tests_failed++;
            $display("FAIL irq_cleared: irq=%b expected 0", irq);
        end
        rd(A_TCON, 32'h3, "tcon_cleared");
        rd(A_TL, 32'hFFFF_FFFD, "tl_after_clear");
    endtask

    task automatic test_collision;
        @(negedge clk);
        wr(A_TCON, 32'h0);
        wr(A_TH, 32'd100);
        wr(A_TL, 32'hFFFF_FFFE);
        wr(A_TCON, 32'h1);
        @(negedge clk);
        rd(A_TL, 32'hFFFF_FFFF, "tl_pre_collision");
        wr(A_TL, 32'd5);
        rd(A_TL, 32'd5, "tl_sw_write_wins");
        rd(A_TCON, 32'h1, "tcon_unchanged");
        @(negedge clk);
        rd(A_TL, 32'd6, "tl_counts_after_write");
        wr(A_TCON, 32'h0);
        wr(A_TL, 32'hFFFF_FFFE);
        wr(A_TCON, 32'h1);
        @(negedge clk);
        wr(A_TH, 32'd200);
        rd(A_TL, 32'd100, "tl_reloads_old_th");
        rd(A_TH, 32'd200, "th_written_on_ovf");
        wr(A_TCON, 32'h0);
    endtask

    task automatic test_periph;
        @(negedge clk);
        switch = 8'hA5;
        rd(A_SW, 32'h0000_00A5, "switch_read");
        wr(A_LED, 32'h3C);
        tests_run++;
        if (led !== 8'h3C) begin
            tests_failed++;
            $display("FAIL led_store: led=%h expected 3c", led);
        end
        rd(A_LED, 32'h3C, "led_read");
        wr(A_SW, 32'hFFFF_FFFF);
        rd(A_SW, 32'h0000_00A5, "switch_read_only");
        tests_run++;
        if (led !== 8'h3C) begin
            tests_failed++;
            $display("FAIL led_after_sw_store: led=%h expected 3c", led);
        end
        wr(A_DIGI, 32'hFFFF_FABC);
        tests_run++;
        if (digi !== 12'hABC) begin
            tests_failed++;
            $display("FAIL digi_store: digi=%h expected abc", digi);
        end
        rd(A_DIGI, 32'h0000_0ABC, "digi_read");
        wr(PB + 32'h1C, 32'h1234);
        rd(PB + 32'h1C, 32'h0, "unmapped_read");
        wr(A_SYSTICK, 32'h0);
        rd(A_SYSTICK, tb_tick, "systick_not_writable");
        wr(A_TCON, 32'hFFFF_FFF8);
        rd(A_TCON, 32'h0, "tcon_upper_bits");
    endtask

    task automatic test_rw_same_cycle;
        @(negedge clk);
        wr(32'h0000_0024, 32'd7);
        exp_q.push_back(32'd7);
        name_q.push_back("rw_old_value");
        addr = 32'h0000_0024;
        wdata = 32'd9;
        mem_write = 1'b1;
        mem_read = 1'b1;
        #1;
        -> rd_ev;
        @(negedge clk);
        mem_write = 1'b0;
        mem_read = 1'b0;
        rd(32'h0000_0024, 32'd9, "rw_new_value");
    endtask

    task automatic test_reset_abort;
        @(negedge clk);
        wr(32'h0000_0028, 32'd11);
        wr(A_LED, 32'h77);
        addr = 32'h0000_0028;
        wdata = 32'd22;
        mem_write = 1'b1;
        #2 reset = 1'b0;
        #1;
        tests_run++;
        if (led !== 8'h00) begin
            tests_failed++;
            $display("FAIL led_async_clear: led=%h expected 00", led);
        end
        @(negedge clk);
        mem_write = 1'b0;
        reset = 1'b1;
        rd(32'h0000_0028, 32'd11, "ram_store_aborted");
        rd(A_LED, 32'h0, "led_read_after_abort");
    endtask

    initial begin
        fork
            forever begin : sb_mon
                logic [31:0] e;
                string       n;
                @(rd_ev);
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL scoreboard_underflow: rdata=%h with no expectation", rdata);
                end else begin
                    e = exp_q.pop_front();
                    n = name_q.pop_front();
                    if (rdata !== e) begin
                        tests_failed++;
                        $display("FAIL %s: rdata=%h expected %h", n, rdata, e);
                    end
                end
            end
        join_none

        test_reset();
        test_ram();
        test_timer();
        test_collision();
        test_periph();
        test_rw_same_cycle();
        test_reset_abort();

        #5;
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
